multicycle_control_unit: RTL



---
 rtl/mcu_pkg.sv | 68 ++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// The state ordering fixes the debug encoding seen on state_o.
package mcu_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    LUI       = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WRITE = 4'd7,
    MEM_WB    = 4'd8,
    ALU_WB    = 4'd9,
    BRANCH    = 4'd10,
    JALR_ADDR = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_RFUNCT   = 2'b10;
  localparam logic [1:0] ALU_IFUNCT   = 2'b11;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_MEM      = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the wait cycle that uses up the budget.
// LIMIT = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  // count holds the waits already spent, so this wait is the LIMIT-th one
  assign expired = (LIMIT > 0) && enable && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port with a ready handshake, wait timeout and traps.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       branch_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       retire_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [3:0] state_o
);

  state_e     state, state_next;
  logic [1:0] cause, cause_next;
  ctrl_t      ctrl, ctrl_gated;
  logic       waiting, expired;

  assign waiting = ((state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE))
                   && !mem_ready_i;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (TO_W)
  ) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clear   (state_next != state),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FETCH;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    ctrl       = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = DECODE;
        end else if (expired) begin
          state_next = TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        case (opcode_i)
          OP_R:               state_next = EXEC_R;
          OP_I:               state_next = EXEC_I;
          OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
          OP_BRANCH:          state_next = BRANCH;
          OP_JAL:             state_next = JUMP;
          OP_JALR:            state_next = JALR_ADDR;
          OP_LUI:             state_next = LUI;
          default: begin
            state_next = TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_RFUNCT;
        state_next     = ALU_WB;
      end
      EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_IFUNCT;
        state_next     = ALU_WB;
      end
      LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = ALU_WB;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = (opcode_i == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready_i) begin
          state_next = MEM_WB;
        end else if (expired) begin
          state_next = TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready_i) begin
          ctrl.retire = 1'b1;
          state_next  = FETCH;
        end else if (expired) begin
          state_next = TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end
      ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.branch     = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end
      JALR_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = JUMP;
      end
      JUMP: begin
        // PC takes the target already in ALUOut while the ALU forms the link value
        ctrl.pc_write   = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_ADD;
        state_next      = ALU_WB;
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = TRAP;
      end
    endcase
  end

  // Enables are forced off while reset is held so an aborted access stops at once
  assign ctrl_gated = rst_ni ? ctrl : '0;

  assign pc_write_o   = ctrl_gated.pc_write;
  assign ir_write_o   = ctrl_gated.ir_write;
  assign iord_o       = ctrl_gated.iord;
  assign mem_read_o   = ctrl_gated.mem_read;
  assign mem_write_o  = ctrl_gated.mem_write;
  assign reg_write_o  = ctrl_gated.reg_write;
  assign branch_o     = ctrl_gated.branch;
  assign alu_src_a_o  = ctrl_gated.alu_src_a;
  assign alu_src_b_o  = ctrl_gated.alu_src_b;
  assign alu_op_o     = ctrl_gated.alu_op;
  assign result_src_o = ctrl_gated.result_src;
  assign retire_o     = ctrl_gated.retire;
  assign trap_o       = (state == TRAP);
  assign trap_cause_o = cause;
  assign state_o      = state;

endmodule
